// File: rtl/ray_dir_gen.sv
// ray_dir_gen: sweeps one frame of ray directions for a column raycaster.
// For each screen column it computes the ray angle from a Q10.8 accumulator.
// It then looks up cos/sin of that angle through an external combinational
// trig LUT, and presents the result on a valid/ready output handshake.
//
// Build option: define RAYGEN_FISHEYE_EN to include the REL step. That step
// does a second LUT lookup of cos(ray angle - player angle) for fisheye
// correction. Without it, ray_cos_rel is the constant 1.0 and each column
// takes one cycle less.
module ray_dir_gen #(
  parameter int WIDTH_TRIG  = 20,   // signed Q4.16 trig width
  parameter int FRAC_BITS   = 16,   // 1.0 == 2**FRAC_BITS
  parameter int NUM_COLS    = 320,  // columns per frame
  parameter int HALF_FOV    = 85,   // half field of view, 1024 units per turn
  parameter int ANG_STEP_Q8 = 137   // per-column angle step, unsigned Q10.8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [9:0]            player_angle,
  output logic [9:0]            lut_angle,
  input  logic [WIDTH_TRIG-1:0] lut_sin,
  input  logic [WIDTH_TRIG-1:0] lut_cos,
  output logic                  ray_valid,
  input  logic                  ray_ready,
  output logic [8:0]            ray_col,
  output logic [WIDTH_TRIG-1:0] ray_dir_x,
  output logic [WIDTH_TRIG-1:0] ray_dir_y,
  output logic [WIDTH_TRIG-1:0] ray_cos_rel,
  output logic                  ray_last,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [9:0]  HALF_FOV_A = 10'(HALF_FOV);
  localparam logic [17:0] ANG_STEP   = 18'(ANG_STEP_Q8);
  localparam logic [8:0]  LAST_COL   = 9'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAY  = 2'd1,
    ST_REL  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [8:0]            r_col;
  logic [17:0]           r_acc;
  logic [9:0]            r_lut_angle;
  logic [WIDTH_TRIG-1:0] r_dir_x;
  logic [WIDTH_TRIG-1:0] r_dir_y;
  logic                  r_frame_done;

  logic        w_accept;
  logic        w_xfer;
  logic        w_last_col;
  logic [17:0] w_acc_start;
  logic [17:0] w_acc_step;

  // A new frame is only taken in IDLE; requests at any other time are dropped.
  assign w_accept    = (r_state == ST_IDLE) && frame_start;
  assign w_xfer      = (r_state == ST_OUT) && ray_ready;
  assign w_last_col  = (r_col == LAST_COL);
  // The subtraction is 10 bits wide, so the left edge wraps modulo 1024.
  assign w_acc_start = {player_angle - HALF_FOV_A, 8'd0};
  assign w_acc_step  = r_acc + ANG_STEP;

`ifdef RAYGEN_FISHEYE_EN
  logic [9:0]            r_player_angle;
  logic [WIDTH_TRIG-1:0] r_cos_rel;
  logic [9:0]            w_rel_angle;

  assign w_rel_angle = r_acc[17:8] - r_player_angle;

  // Latch the frame's view angle so the relative angle does not follow the input port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_player_angle <= 10'd0;
    end else if (w_accept) begin
      r_player_angle <= player_angle;
    end
  end

  // Capture the fisheye correction term from the second LUT lookup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cos_rel <= '0;
    end else if (r_state == ST_REL) begin
      r_cos_rel <= lut_cos;
    end
  end

  assign ray_cos_rel = r_cos_rel;
`else
  localparam logic [WIDTH_TRIG-1:0] TRIG_ONE = {{(WIDTH_TRIG-1){1'b0}}, 1'b1} << FRAC_BITS;

  assign ray_cos_rel = TRIG_ONE;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_state_next = ST_RAY;
        end
      end
      ST_RAY: begin
`ifdef RAYGEN_FISHEYE_EN
        w_state_next = ST_REL;
`else
        w_state_next = ST_OUT;
`endif
      end
      ST_REL: begin
        w_state_next = ST_OUT;
      end
      ST_OUT: begin
        if (ray_ready) begin
          w_state_next = w_last_col ? ST_IDLE : ST_RAY;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Column counter and angle accumulator: start at the left FOV edge, step once per transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= 9'd0;
      r_acc <= 18'd0;
    end else if (w_accept) begin
      r_col <= 9'd0;
      r_acc <= w_acc_start;
    end else if (w_xfer && !w_last_col) begin
      r_col <= r_col + 9'd1;
      r_acc <= w_acc_step;
    end
  end

  // LUT address register. It is loaded one edge ahead, so it already shows the
  // right angle during the lookup cycle. It holds its last value otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lut_angle <= 10'd0;
    end else if (w_accept) begin
      r_lut_angle <= w_acc_start[17:8];
    end else if (w_xfer && !w_last_col) begin
      r_lut_angle <= w_acc_step[17:8];
`ifdef RAYGEN_FISHEYE_EN
    end else if (r_state == ST_RAY) begin
      r_lut_angle <= w_rel_angle;
`endif
    end
  end

  // Capture the ray direction in the RAY cycle. It stays frozen through OUT, including stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir_x <= '0;
      r_dir_y <= '0;
    end else if (r_state == ST_RAY) begin
      r_dir_x <= lut_cos;
      r_dir_y <= lut_sin;
    end
  end

  // One-cycle completion pulse after the last column is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_xfer && w_last_col;
    end
  end

  assign lut_angle  = r_lut_angle;
  assign ray_valid  = (r_state == ST_OUT);
  assign ray_col    = r_col;
  assign ray_dir_x  = r_dir_x;
  assign ray_dir_y  = r_dir_y;
  assign ray_last   = (r_state == ST_OUT) && w_last_col;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;

endmodule
